// File: rtl/risc_pkg.sv
// Shared opcode definitions for the 16-bit RISC pipeline (decode, hazard and writeback).
package risc_pkg;

  localparam logic [3:0] OP_ADI  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_JAL  = 4'b1001;
  localparam logic [3:0] OP_JLR  = 4'b1010;
  localparam logic [3:0] OP_JRI  = 4'b1011;
  localparam logic [3:0] NOP_OP  = 4'b1111;

  typedef enum logic [1:0] {
    SelAlu,
    SelMem,
    SelPc
  } wb_sel_e;

endpackage

// File: rtl/regfile_8x16.sv
// Architectural register storage: one synchronous write port, two raw asynchronous read ports.
module regfile_8x16 #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  localparam int unsigned NumRegs = 2 ** AW;

  logic [DW-1:0] mem_q [NumRegs];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register file commit with write-first bypass,
// R7 write pulse for fetch redirect, and retired-instruction counter.
module wb_regfile #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 3,
  parameter logic [3:0]  NOP_OP = risc_pkg::NOP_OP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          WB_EN,
  input  logic [15:0]   IR_IN,
  input  logic [AW-1:0] DEST_IN,
  input  logic [DW-1:0] ALU_C_IN,
  input  logic [DW-1:0] D_OUT_IN,
  input  logic [DW-1:0] PC_2_IN,
  input  logic [AW-1:0] RA_ADDR,
  input  logic [AW-1:0] RB_ADDR,
  output logic [DW-1:0] RA_DATA,
  output logic [DW-1:0] RB_DATA,
  output logic          WB_WE,
  output logic [AW-1:0] WB_DEST,
  output logic [DW-1:0] WB_DATA,
  output logic          R7_WR,
  output logic [15:0]   RETIRED
);

  logic [3:0]        opcode;
  logic              wr_class;
  risc_pkg::wb_sel_e wb_sel;
  logic              retire;
  logic [DW-1:0]     raw_a, raw_b;
  logic              r7_wr_q;
  logic [15:0]       retired_q, retired_d;

  assign opcode = IR_IN[15:12];

  always_comb begin
    wb_sel   = risc_pkg::SelAlu;
    wr_class = 1'b0;
    case (opcode)
      risc_pkg::OP_LW, risc_pkg::OP_LM: begin
        wb_sel   = risc_pkg::SelMem;
        wr_class = 1'b1;
      end
      risc_pkg::OP_JAL, risc_pkg::OP_JLR: begin
        wb_sel   = risc_pkg::SelPc;
        wr_class = 1'b1;
      end
      risc_pkg::OP_ADI, risc_pkg::OP_ADD, risc_pkg::OP_NAND, risc_pkg::OP_LHI: begin
        wr_class = 1'b1;
      end
      default: ;
    endcase
    // A bubble never writes, even if NOP_OP is overridden onto a write opcode.
    if (opcode == NOP_OP) begin
      wr_class = 1'b0;
      wb_sel   = risc_pkg::SelAlu;
    end
  end

  always_comb begin
    WB_DATA = ALU_C_IN;
    case (wb_sel)
      risc_pkg::SelMem: WB_DATA = D_OUT_IN;
      risc_pkg::SelPc:  WB_DATA = PC_2_IN;
      default:          WB_DATA = ALU_C_IN;
    endcase
  end

  // Gated by rst_n so nothing is committed or bypassed while reset is held.
  assign WB_WE   = WB_EN & wr_class & rst_n;
  assign WB_DEST = DEST_IN;
  assign retire  = WB_EN && (opcode != NOP_OP);

  regfile_8x16 #(
    .DW(DW),
    .AW(AW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (WB_WE),
    .waddr  (DEST_IN),
    .wdata  (WB_DATA),
    .raddr_a(RA_ADDR),
    .rdata_a(raw_a),
    .raddr_b(RB_ADDR),
    .rdata_b(raw_b)
  );

  assign RA_DATA = (WB_WE && (RA_ADDR == DEST_IN)) ? WB_DATA : raw_a;
  assign RB_DATA = (WB_WE && (RB_ADDR == DEST_IN)) ? WB_DATA : raw_b;

  assign retired_d = retire ? retired_q + 16'd1 : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r7_wr_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      r7_wr_q   <= WB_WE && (DEST_IN == {AW{1'b1}});
      retired_q <= retired_d;
    end
  end

  assign R7_WR   = r7_wr_q;
  assign RETIRED = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile with hand-computed expectations.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        WB_EN;
  logic [15:0] IR_IN;
  logic [2:0]  DEST_IN;
  logic [15:0] ALU_C_IN;
  logic [15:0] D_OUT_IN;
  logic [15:0] PC_2_IN;
  logic [2:0]  RA_ADDR;
  logic [2:0]  RB_ADDR;
  logic [15:0] RA_DATA;
  logic [15:0] RB_DATA;
  logic        WB_WE;
  logic [2:0]  WB_DEST;
  logic [15:0] WB_DATA;
  logic        R7_WR;
  logic [15:0] RETIRED;

  int unsigned n_checks;
  int unsigned n_fails;

  wb_regfile u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .WB_EN   (WB_EN),
    .IR_IN   (IR_IN),
    .DEST_IN (DEST_IN),
    .ALU_C_IN(ALU_C_IN),
    .D_OUT_IN(D_OUT_IN),
    .PC_2_IN (PC_2_IN),
    .RA_ADDR (RA_ADDR),
    .RB_ADDR (RB_ADDR),
    .RA_DATA (RA_DATA),
    .RB_DATA (RB_DATA),
    .WB_WE   (WB_WE),
    .WB_DEST (WB_DEST),
    .WB_DATA (WB_DATA),
    .R7_WR   (R7_WR),
    .RETIRED (RETIRED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_wb(input logic en, input logic [15:0] ir, input logic [2:0] dest,
                        input logic [15:0] alu, input logic [15:0] dout,
                        input logic [15:0] pc2);
    WB_EN    = en;
    IR_IN    = ir;
    DEST_IN  = dest;
    ALU_C_IN = alu;
    D_OUT_IN = dout;
    PC_2_IN  = pc2;
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    RA_ADDR  = '0;
    RB_ADDR  = '0;
    set_wb(1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    repeat (2) tick();
    check("reset_retired", RETIRED, 16'h0000);
    check("reset_r7_wr", {15'd0, R7_WR}, 16'h0000);
    rst_n = 1'b1;
    #1;

    // ADD with same-cycle bypass, then read from storage
    set_wb(1'b1, 16'h1abc, 3'd3, 16'h1234, 16'h9999, 16'h8888);
    RA_ADDR = 3'd3;
    RB_ADDR = 3'd0;
    #1;
    check("add_we", {15'd0, WB_WE}, 16'h0001);
    check("add_bypass_a", RA_DATA, 16'h1234);
    check("add_no_bypass_b", RB_DATA, 16'h0000);
    check("add_dest", {13'd0, WB_DEST}, 16'h0003);
    tick();
    set_wb(1'b0, 16'h1abc, 3'd3, 16'h0000, 16'h0000, 16'h0000);
    RB_ADDR = 3'd3;
    #1;
    check("add_stored_b", RB_DATA, 16'h1234);
    check("add_retired", RETIRED, 16'h0001);

    // LW selects memory data
    set_wb(1'b1, 16'h4000, 3'd5, 16'h0004, 16'hbeef, 16'h0000);
    #1;
    check("lw_wbdata", WB_DATA, 16'hbeef);
    tick();
    set_wb(1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    RA_ADDR = 3'd5;
    #1;
    check("lw_stored", RA_DATA, 16'hbeef);

    // JAL to R7: one-cycle R7_WR pulse
    set_wb(1'b1, 16'h9000, 3'd7, 16'h0011, 16'h0022, 16'h0042);
    #1;
    check("jal_wbdata", WB_DATA, 16'h0042);
    check("jal_r7_before", {15'd0, R7_WR}, 16'h0000);
    tick();
    check("jal_r7_pulse", {15'd0, R7_WR}, 16'h0001);
    set_wb(1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    RA_ADDR = 3'd7;
    #1;
    check("jal_stored", RA_DATA, 16'h0042);
    tick();
    check("jal_r7_after", {15'd0, R7_WR}, 16'h0000);
    check("jal_retired", RETIRED, 16'h0003);

    // LM and JLR select values (no commit)
    set_wb(1'b0, 16'h6000, 3'd4, 16'h0001, 16'h0606, 16'h0a0a);
    #1;
    check("lm_wbdata", WB_DATA, 16'h0606);
    IR_IN = 16'ha000;
    #1;
    check("jlr_wbdata", WB_DATA, 16'h0a0a);
    check("en0_we", {15'd0, WB_WE}, 16'h0000);

    // Preload R2, then non-writing classes
    set_wb(1'b1, 16'h0005, 3'd2, 16'h2222, 16'h0000, 16'h0000);
    tick();
    RA_ADDR = 3'd2;
    set_wb(1'b1, 16'h5000, 3'd2, 16'hdead, 16'hface, 16'hcafe);
    #1;
    check("sw_we", {15'd0, WB_WE}, 16'h0000);
    check("sw_wbdata", WB_DATA, 16'hdead);
    check("sw_no_bypass", RA_DATA, 16'h2222);
    tick();
    set_wb(1'b1, 16'h8000, 3'd2, 16'hdead, 16'hface, 16'hcafe);
    #1;
    check("beq_we", {15'd0, WB_WE}, 16'h0000);
    tick();
    set_wb(1'b1, 16'hf000, 3'd2, 16'hdead, 16'hface, 16'hcafe);
    #1;
    check("nop_we", {15'd0, WB_WE}, 16'h0000);
    tick();
    set_wb(1'b0, 16'h1000, 3'd2, 16'hdead, 16'hface, 16'hcafe);
    #1;
    check("en0_add_we", {15'd0, WB_WE}, 16'h0000);
    tick();
    check("r2_unchanged", RA_DATA, 16'h2222);
    check("nowrite_retired", RETIRED, 16'h0006);

    // Back-to-back writes to R1, both ports bypassing
    RA_ADDR = 3'd1;
    RB_ADDR = 3'd1;
    set_wb(1'b1, 16'h1000, 3'd1, 16'haaaa, 16'h0000, 16'h0000);
    #1;
    check("b2b_a_first", RA_DATA, 16'haaaa);
    check("b2b_b_first", RB_DATA, 16'haaaa);
    tick();
    set_wb(1'b1, 16'h1000, 3'd1, 16'h5555, 16'h0000, 16'h0000);
    #1;
    check("b2b_a_second", RA_DATA, 16'h5555);
    check("b2b_b_second", RB_DATA, 16'h5555);
    tick();
    set_wb(1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    #1;
    check("b2b_stored", RA_DATA, 16'h5555);

    // Mid-run asynchronous reset right after an R7 write
    set_wb(1'b1, 16'h9000, 3'd7, 16'h0000, 16'h0000, 16'h0100);
    tick();
    set_wb(1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("rst_r7_wr", {15'd0, R7_WR}, 16'h0000);
    check("rst_retired", RETIRED, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      RA_ADDR = 3'(i);
      RB_ADDR = 3'(7 - i);
      #1;
      check($sformatf("rst_ra%0d", i), RA_DATA, 16'h0000);
      check($sformatf("rst_rb%0d", 7 - i), RB_DATA, 16'h0000);
    end
    // An edge under reset must not commit or count
    set_wb(1'b1, 16'h1000, 3'd3, 16'h7777, 16'h0000, 16'h0000);
    tick();
    set_wb(1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    rst_n   = 1'b1;
    RA_ADDR = 3'd3;
    #1;
    check("rst_edge_nowrite", RA_DATA, 16'h0000);
    check("rst_edge_nocount", RETIRED, 16'h0000);

    // Counter wrap: 65534 retirements to FFFE, then three more
    set_wb(1'b1, 16'h5000, 3'd0, 16'h0000, 16'h0000, 16'h0000);
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_fffe", RETIRED, 16'hfffe);
    tick();
    check("cnt_ffff", RETIRED, 16'hffff);
    tick();
    check("cnt_wrap0", RETIRED, 16'h0000);
    tick();
    check("cnt_0001", RETIRED, 16'h0001);
    WB_EN = 1'b0;
    tick();
    check("cnt_hold", RETIRED, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
